// File: rtl/branch_predictor_if.sv
// Fetch-lookup / execute-resolve bundle between the pipeline and the branch predictor.
interface branch_predictor_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned GHR_W      = 4
);
    // Fetch-side lookup
    logic [DATA_WIDTH-1:0] pc_f;
    logic                  pred_taken_f;
    logic [DATA_WIDTH-1:0] pred_target_f;
    logic [DATA_WIDTH-1:0] pred_next_pc_f;
    logic [GHR_W-1:0]      ghr_f;

    // Execute-side resolution
    logic                  update_en_e;
    logic                  is_jump_e;
    logic [DATA_WIDTH-1:0] pc_e;
    logic                  taken_e;
    logic [DATA_WIDTH-1:0] target_e;
    logic                  pred_taken_e;
    logic [DATA_WIDTH-1:0] pred_target_e;
    logic [GHR_W-1:0]      ghr_e;
    logic                  mispredict_e;
    logic [DATA_WIDTH-1:0] redirect_pc_e;

    // Pipeline side
    modport master (
        output pc_f,
        input  pred_taken_f,
        input  pred_target_f,
        input  pred_next_pc_f,
        input  ghr_f,
        output update_en_e,
        output is_jump_e,
        output pc_e,
        output taken_e,
        output target_e,
        output pred_taken_e,
        output pred_target_e,
        output ghr_e,
        input  mispredict_e,
        input  redirect_pc_e
    );

    // Predictor side
    modport slave (
        input  pc_f,
        output pred_taken_f,
        output pred_target_f,
        output pred_next_pc_f,
        output ghr_f,
        input  update_en_e,
        input  is_jump_e,
        input  pc_e,
        input  taken_e,
        input  target_e,
        input  pred_taken_e,
        input  pred_target_e,
        input  ghr_e,
        output mispredict_e,
        output redirect_pc_e
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Zero-latency lookup at fetch, table/history update at execute resolution.
// MODE=0 indexes bimodally by PC, MODE=1 folds the global history in (gshare).
module branch_predictor #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ENTRIES    = 16,
    parameter int unsigned GHR_W      = 4,
    parameter int unsigned MODE       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_predictor_if.slave    bp
);
    localparam int unsigned IDX_W   = $clog2(ENTRIES);
    localparam int unsigned TAG_LSB = IDX_W + 2;
    localparam int unsigned TAG_W   = DATA_WIDTH - TAG_LSB;

    // Table storage
    logic                  r_valid  [ENTRIES];
    logic                  r_jump   [ENTRIES];
    logic [TAG_W-1:0]      r_tag    [ENTRIES];
    logic [DATA_WIDTH-1:0] r_target [ENTRIES];
    logic [1:0]            r_ctr    [ENTRIES];
    logic [GHR_W-1:0]      r_ghr;

    // Fetch-side lookup signals
    logic [IDX_W-1:0]      w_idx_f;
    logic [TAG_W-1:0]      w_tag_f;
    logic                  w_hit_f;
    logic                  w_pred_taken_f;
    logic [DATA_WIDTH-1:0] w_pc_plus4_f;

    // Execute-side update signals
    logic [IDX_W-1:0]      w_idx_e;
    logic [TAG_W-1:0]      w_tag_e;
    logic                  w_hit_e;
    logic [1:0]            w_ctr_e;
    logic [1:0]            w_ctr_next_e;
    logic                  w_mispredict_e;
    logic [DATA_WIDTH-1:0] w_pc_plus4_e;

    // Bits that intentionally do not affect the result (word-aligned PCs, unused history MSB)
    logic                  w_unused;
    assign w_unused = ^{bp.pc_f[1:0], bp.pc_e[1:0], bp.ghr_e};

    // Table index: PC word bits, optionally XORed with zero-extended history
    always_comb begin
        w_idx_f = bp.pc_f[IDX_W+1:2];
        w_idx_e = bp.pc_e[IDX_W+1:2];
        if (MODE == 1) begin
            w_idx_f = bp.pc_f[IDX_W+1:2] ^ IDX_W'(r_ghr);
            w_idx_e = bp.pc_e[IDX_W+1:2] ^ IDX_W'(bp.ghr_e);
        end
    end

    assign w_tag_f = bp.pc_f[DATA_WIDTH-1:TAG_LSB];
    assign w_tag_e = bp.pc_e[DATA_WIDTH-1:TAG_LSB];

    // Fetch lookup: jumps are always predicted taken once learned, branches follow ctr MSB
    always_comb begin
        w_hit_f        = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
        w_pred_taken_f = w_hit_f && (r_ctr[w_idx_f][1] || r_jump[w_idx_f]);
        w_pc_plus4_f   = bp.pc_f + DATA_WIDTH'(4);
    end

    assign bp.pred_taken_f   = w_pred_taken_f;
    assign bp.pred_target_f  = r_target[w_idx_f];
    assign bp.pred_next_pc_f = w_pred_taken_f ? r_target[w_idx_f] : w_pc_plus4_f;
    assign bp.ghr_f          = r_ghr;

    // Resolution: hit detection and saturating counter step for the resolving entry
    always_comb begin
        w_hit_e      = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);
        w_ctr_e      = r_ctr[w_idx_e];
        w_ctr_next_e = w_ctr_e;
        if (bp.taken_e) begin
            if (w_ctr_e != 2'b11) begin
                w_ctr_next_e = w_ctr_e + 2'd1;
            end
        end else begin
            if (w_ctr_e != 2'b00) begin
                w_ctr_next_e = w_ctr_e - 2'd1;
            end
        end
    end

    // Mispredict: wrong direction, or taken to a different target; suppressed while in reset
    always_comb begin
        w_mispredict_e = bp.update_en_e &&
                         ((bp.pred_taken_e != bp.taken_e) ||
                          (bp.taken_e && (bp.pred_target_e != bp.target_e)));
        w_pc_plus4_e   = bp.pc_e + DATA_WIDTH'(4);
    end

    assign bp.mispredict_e  = w_mispredict_e && !rst;
    assign bp.redirect_pc_e = bp.taken_e ? bp.target_e : w_pc_plus4_e;

    // Table update on resolution; reset clears everything and blocks any concurrent write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_jump[i]   <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (bp.update_en_e) begin
            if (w_hit_e) begin
                if (bp.is_jump_e) begin
                    r_ctr[w_idx_e]  <= 2'b11;
                    r_jump[w_idx_e] <= 1'b1;
                end else begin
                    r_ctr[w_idx_e]  <= w_ctr_next_e;
                end
                if (bp.taken_e) begin
                    r_target[w_idx_e] <= bp.target_e;
                end
            end else if (bp.taken_e) begin
                r_valid[w_idx_e]  <= 1'b1;
                r_tag[w_idx_e]    <= w_tag_e;
                r_target[w_idx_e] <= bp.target_e;
                r_ctr[w_idx_e]    <= bp.is_jump_e ? 2'b11 : 2'b10;
                r_jump[w_idx_e]   <= bp.is_jump_e;
            end
        end
    end

    // Global history: rebuilt from the history that travelled with the branch, so a
    // resolved conditional branch also repairs any wrong-path speculation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ghr <= '0;
        end else if ((MODE == 1) && bp.update_en_e && !bp.is_jump_e) begin
            r_ghr <= GHR_W'({bp.ghr_e, bp.taken_e});
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: bimodal instance (dut 0) and gshare instance (dut 1).
module tb_branch_predictor;
    localparam int unsigned DW  = 32;
    localparam int unsigned ENT = 16;
    localparam int unsigned GW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_predictor_if #(.DATA_WIDTH(DW), .GHR_W(GW)) bp0 ();
    branch_predictor_if #(.DATA_WIDTH(DW), .GHR_W(GW)) bp1 ();

    branch_predictor #(.DATA_WIDTH(DW), .ENTRIES(ENT), .GHR_W(GW), .MODE(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bp  (bp0)
    );

    branch_predictor #(.DATA_WIDTH(DW), .ENTRIES(ENT), .GHR_W(GW), .MODE(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bp  (bp1)
    );

    typedef struct {
        string       name;
        int unsigned dut;
        bit          chk_pred;
        bit          exp_taken;
        logic [31:0] exp_next;
        bit          chk_tgt;
        logic [31:0] exp_tgt;
        bit          chk_ghr;
        logic [3:0]  exp_ghr;
        bit          chk_mis;
        bit          exp_mis;
        logic [31:0] exp_redir;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic exp_t blank(input int unsigned d, input string nm);
        exp_t e;
        e.name      = nm;
        e.dut       = d;
        e.chk_pred  = 1'b0;
        e.exp_taken = 1'b0;
        e.exp_next  = '0;
        e.chk_tgt   = 1'b0;
        e.exp_tgt   = '0;
        e.chk_ghr   = 1'b0;
        e.exp_ghr   = '0;
        e.chk_mis   = 1'b0;
        e.exp_mis   = 1'b0;
        e.exp_redir = '0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: compare every queued expectation against live outputs mid-cycle
    always @(negedge clk) begin
        exp_t        e;
        logic        a_tk;
        logic        a_mis;
        logic [31:0] a_nxt;
        logic [31:0] a_tgt;
        logic [31:0] a_redir;
        logic [3:0]  a_ghr;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dut == 0) begin
                a_tk = bp0.pred_taken_f;  a_nxt = bp0.pred_next_pc_f; a_tgt = bp0.pred_target_f;
                a_ghr = bp0.ghr_f;        a_mis = bp0.mispredict_e;   a_redir = bp0.redirect_pc_e;
            end else begin
                a_tk = bp1.pred_taken_f;  a_nxt = bp1.pred_next_pc_f; a_tgt = bp1.pred_target_f;
                a_ghr = bp1.ghr_f;        a_mis = bp1.mispredict_e;   a_redir = bp1.redirect_pc_e;
            end
            if (e.chk_pred) begin
                chk({e.name, ".pred_taken"}, 32'(a_tk), 32'(e.exp_taken));
                chk({e.name, ".next_pc"}, a_nxt, e.exp_next);
            end
            if (e.chk_tgt) chk({e.name, ".target"}, a_tgt, e.exp_tgt);
            if (e.chk_ghr) chk({e.name, ".ghr"}, 32'(a_ghr), 32'(e.exp_ghr));
            if (e.chk_mis) begin
                chk({e.name, ".mispredict"}, 32'(a_mis), 32'(e.exp_mis));
                chk({e.name, ".redirect"}, a_redir, e.exp_redir);
            end
        end
    end

    // Drive a fetch lookup and queue its expected prediction
    task automatic look(input int unsigned d, input string nm, input logic [31:0] pc,
                        input bit tk, input logic [31:0] nxt);
        exp_t e;
        if (d == 0) bp0.pc_f = pc; else bp1.pc_f = pc;
        e = blank(d, nm);
        e.chk_pred  = 1'b1;
        e.exp_taken = tk;
        e.exp_next  = nxt;
        e.chk_tgt   = tk;
        e.exp_tgt   = nxt;
        sb.push_back(e);
    endtask

    task automatic expect_ghr(input int unsigned d, input string nm, input logic [3:0] g);
        exp_t e;
        e = blank(d, nm);
        e.chk_ghr = 1'b1;
        e.exp_ghr = g;
        sb.push_back(e);
    endtask

    // Drive an execute-stage resolution and queue the expected mispredict/redirect
    task automatic resolve(input int unsigned d, input string nm, input logic [31:0] pc,
                           input bit jmp, input bit tk, input logic [31:0] tgt,
                           input bit ptk, input logic [31:0] ptgt, input logic [3:0] g,
                           input bit emis, input logic [31:0] eredir);
        exp_t e;
        if (d == 0) begin
            bp0.update_en_e = 1'b1; bp0.is_jump_e = jmp; bp0.pc_e = pc; bp0.taken_e = tk;
            bp0.target_e = tgt; bp0.pred_taken_e = ptk; bp0.pred_target_e = ptgt; bp0.ghr_e = g;
        end else begin
            bp1.update_en_e = 1'b1; bp1.is_jump_e = jmp; bp1.pc_e = pc; bp1.taken_e = tk;
            bp1.target_e = tgt; bp1.pred_taken_e = ptk; bp1.pred_target_e = ptgt; bp1.ghr_e = g;
        end
        e = blank(d, nm);
        e.chk_mis   = 1'b1;
        e.exp_mis   = emis;
        e.exp_redir = eredir;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bp0.update_en_e = 1'b0;
        bp1.update_en_e = 1'b0;
    endtask

    initial begin
        bit          p_tk;
        logic [31:0] p_tgt;
        logic [3:0]  p_ghr;
        bit          k_taken;
        bit          exp_pt;
        logic [3:0]  exp_g;
        int          budget;

        bp0.pc_f = '0; bp0.update_en_e = 0; bp0.is_jump_e = 0; bp0.pc_e = '0; bp0.taken_e = 0;
        bp0.target_e = '0; bp0.pred_taken_e = 0; bp0.pred_target_e = '0; bp0.ghr_e = '0;
        bp1.pc_f = '0; bp1.update_en_e = 0; bp1.is_jump_e = 0; bp1.pc_e = '0; bp1.taken_e = 0;
        bp1.target_e = '0; bp1.pred_taken_e = 0; bp1.pred_target_e = '0; bp1.ghr_e = '0;

        // Reset: miss, fall-through, update ignored and mispredict held low
        look(0, "rst_lookup", 32'h10, 1'b0, 32'h14);
        resolve(0, "rst_update", 32'h10, 1'b0, 1'b1, 32'h500, 1'b0, 32'h14, 4'h0, 1'b0, 32'h500);
        tick();
        rst = 1'b0;
        look(0, "post_rst_miss", 32'h10, 1'b0, 32'h14);
        expect_ghr(0, "bimodal_ghr0", 4'h0);
        tick();

        // Branch 0x20 -> 0x08 taken; same-cycle lookup must not see the write
        resolve(0, "br20_alloc", 32'h20, 1'b0, 1'b1, 32'h08, 1'b0, 32'h24, 4'h0, 1'b1, 32'h08);
        look(0, "br20_nobypass", 32'h20, 1'b0, 32'h24);
        tick();
        look(0, "br20_hit", 32'h20, 1'b1, 32'h08);
        resolve(0, "br20_nt1", 32'h20, 1'b0, 1'b0, 32'h08, 1'b1, 32'h08, 4'h0, 1'b1, 32'h24);
        tick();                                                            // ctr 01
        look(0, "br20_ctr01", 32'h20, 1'b0, 32'h24);
        resolve(0, "br20_nt2", 32'h20, 1'b0, 1'b0, 32'h08, 1'b0, 32'h24, 4'h0, 1'b0, 32'h24);
        tick();                                                            // ctr 00
        resolve(0, "br20_nt3", 32'h20, 1'b0, 1'b0, 32'h08, 1'b0, 32'h24, 4'h0, 1'b0, 32'h24);
        tick();                                                            // ctr holds 00
        resolve(0, "br20_t1", 32'h20, 1'b0, 1'b1, 32'h08, 1'b0, 32'h24, 4'h0, 1'b1, 32'h08);
        tick();                                                            // ctr 01
        look(0, "br20_floor_held", 32'h20, 1'b0, 32'h24);
        resolve(0, "br20_t2", 32'h20, 1'b0, 1'b1, 32'h08, 1'b0, 32'h24, 4'h0, 1'b1, 32'h08);
        tick();                                                            // ctr 10
        look(0, "br20_ctr10", 32'h20, 1'b1, 32'h08);
        resolve(0, "br20_t3", 32'h20, 1'b0, 1'b1, 32'h08, 1'b1, 32'h08, 4'h0, 1'b0, 32'h08);
        tick();                                                            // ctr 11
        resolve(0, "br20_t4", 32'h20, 1'b0, 1'b1, 32'h08, 1'b1, 32'h08, 4'h0, 1'b0, 32'h08);
        tick();                                                            // ctr holds 11
        resolve(0, "br20_nt4", 32'h20, 1'b0, 1'b0, 32'h08, 1'b1, 32'h08, 4'h0, 1'b1, 32'h24);
        tick();                                                            // ctr 10
        look(0, "br20_ceiling_held", 32'h20, 1'b1, 32'h08);
        resolve(0, "br20_nt5", 32'h20, 1'b0, 1'b0, 32'h08, 1'b1, 32'h08, 4'h0, 1'b1, 32'h24);
        tick();                                                            // ctr 01
        look(0, "br20_back_nt", 32'h20, 1'b0, 32'h24);
        tick();

        // JAL 0x40 -> 0x100
        resolve(0, "jal40_alloc", 32'h40, 1'b1, 1'b1, 32'h100, 1'b0, 32'h44, 4'h0, 1'b1, 32'h100);
        tick();
        look(0, "jal40_hit", 32'h40, 1'b1, 32'h100);
        resolve(0, "jal40_badtgt", 32'h40, 1'b1, 1'b1, 32'h100, 1'b1, 32'h0FC, 4'h0, 1'b1, 32'h100);
        tick();
        look(0, "jal40_still", 32'h40, 1'b1, 32'h100);
        resolve(0, "jal40_ok", 32'h40, 1'b1, 1'b1, 32'h100, 1'b1, 32'h100, 4'h0, 1'b0, 32'h100);
        tick();

        // Alias: 0x60 shares index 8 with 0x20 and evicts it
        resolve(0, "br60_alloc", 32'h60, 1'b0, 1'b1, 32'h200, 1'b0, 32'h64, 4'h0, 1'b1, 32'h200);
        tick();
        look(0, "alias20_miss", 32'h20, 1'b0, 32'h24);
        tick();
        look(0, "br60_hit", 32'h60, 1'b1, 32'h200);
        resolve(0, "br60_newtgt", 32'h60, 1'b0, 1'b1, 32'h280, 1'b1, 32'h200, 4'h0, 1'b1, 32'h280);
        tick();
        look(0, "br60_tgt_upd", 32'h60, 1'b1, 32'h280);
        expect_ghr(0, "bimodal_ghr_held", 4'h0);
        tick();

        // PC wrap at the top of the address space; not-taken miss writes nothing
        look(0, "wrap_lookup", 32'hFFFF_FFFC, 1'b0, 32'h0);
        resolve(0, "wrap_redirect", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h40, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
        tick();
        look(0, "wrap_nowrite", 32'hFFFF_FFFC, 1'b0, 32'h0);
        tick();

        // Gshare: alternating T/N branch at 0x80 -> 0x10, history pipelined from fetch
        for (int k = 1; k <= 14; k++) begin
            k_taken = (k % 2) == 1;
            exp_pt  = (k >= 7) && k_taken;
            if (k == 1)      exp_g = 4'b0000;
            else if (k == 2) exp_g = 4'b0001;
            else if (k == 3) exp_g = 4'b0010;
            else             exp_g = ((k % 2) == 0) ? 4'b0101 : 4'b1010;
            look(1, $sformatf("gs_look%0d", k), 32'h80, exp_pt, exp_pt ? 32'h10 : 32'h84);
            expect_ghr(1, $sformatf("gs_ghr%0d", k), exp_g);
            #1;
            p_tk  = bp1.pred_taken_f;
            p_tgt = bp1.pred_target_f;
            p_ghr = bp1.ghr_f;
            tick();
            resolve(1, $sformatf("gs_res%0d", k), 32'h80, 1'b0, k_taken, 32'h10, p_tk, p_tgt, p_ghr,
                    (k <= 5) && k_taken, k_taken ? 32'h10 : 32'h84);
            tick();
        end

        // Reset asserted with updates in flight on both instances
        rst = 1'b1;
        resolve(0, "rst_upd0", 32'hC0, 1'b0, 1'b1, 32'h300, 1'b0, 32'hC4, 4'h0, 1'b0, 32'h300);
        resolve(1, "rst_upd1", 32'h80, 1'b0, 1'b1, 32'h10, 1'b0, 32'h84, 4'b0111, 1'b0, 32'h10);
        look(0, "rst_clears60", 32'h60, 1'b0, 32'h64);
        tick();
        rst = 1'b0;
        look(0, "rst_noalloc_c0", 32'hC0, 1'b0, 32'hC4);
        look(1, "rst_gs_miss80", 32'h80, 1'b0, 32'h84);
        expect_ghr(1, "rst_gs_ghr", 4'h0);
        tick();
        look(0, "rst_miss60", 32'h60, 1'b0, 32'h64);
        tick();

        budget = 10;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
